// File: rtl/tagged_data_pkg.sv
// Shared types and helpers for the tagged data transmitter.
package tagged_data_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

  localparam int unsigned MIN_DEPTH = 2;

  // Occupancy must be able to represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tagged_data_fifo.sv
// DEPTH-entry synchronous FIFO with a registered head that holds its last value when empty.
import tagged_data_pkg::*;

module tagged_data_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;

  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Head is loaded directly from the write port when the incoming word becomes the front entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && ((level == '0) || (pop && (level == LW'(1))))) begin
        head <= wdata;
      end else if (pop && (level > LW'(1))) begin
        head <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/tagged_data_tx.sv
// Transmit-side producer: stamps source words with a running ID and queues them for the consumer.
import tagged_data_pkg::*;

module tagged_data_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        id_clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [ID_WIDTH-1:0]         out_id,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        busy
);

  localparam int LW = level_w(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } entry_t;

  tx_state_t             state_q;
  tx_state_t             state_d;
  logic [ID_WIDTH-1:0]   id_cnt;
  logic                  push;
  logic                  pop;
  entry_t                push_entry;
  entry_t                head;

  assign in_ready   = (state_q == RUN) && (level < LW'(DEPTH));
  assign out_valid  = (level != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign busy       = (state_q != IDLE);
  assign push_entry = '{data: in_data, id: id_cnt};
  assign out_data   = head.data;
  assign out_id     = head.id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping enable with words still queued keeps the block busy until the FIFO empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = (level != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (level == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_cnt <= '0;
    end else if ((state_q == IDLE) && id_clr) begin
      id_cnt <= '0;
    end else if (push) begin
      id_cnt <= id_cnt + 1'b1;
    end
  end

  tagged_data_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .head  (head),
    .level (level)
  );

endmodule

// File: tb/tb_tagged_data_tx.sv
// Randomized and directed checks of tagged_data_tx against a queue-based reference model.
module tb_tagged_data_tx;

  localparam int DW    = 8;
  localparam int IW    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          enable    = 1'b0;
  logic          id_clr    = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  logic [LW-1:0] level;
  logic          busy;

  int checks = 0;
  int errors = 0;

  int          m_state;
  int unsigned m_id;
  int          q_data[$];
  int          q_id[$];
  int          last_data;
  int          last_id;

  tagged_data_tx #(
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .id_clr    (id_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .level     (level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_state   = M_IDLE;
    m_id      = 0;
    q_data    = {};
    q_id      = {};
    last_data = 0;
    last_id   = 0;
  endtask

  task automatic compareAll();
    int n;
    n = q_data.size();
    checkOutput("in_ready",  in_ready,  (m_state == M_RUN) && (n < DEPTH));
    checkOutput("out_valid", out_valid, n != 0);
    checkOutput("level",     level,     n);
    checkOutput("busy",      busy,      m_state != M_IDLE);
    checkOutput("out_data",  out_data,  (n != 0) ? q_data[0] : last_data);
    checkOutput("out_id",    out_id,    (n != 0) ? q_id[0] : last_id);
  endtask

  // One clock: check the current outputs, drive inputs, advance the model, step to the next negedge.
  task automatic applyStimulus(input logic en, input logic clr, input logic iv,
                               input logic [DW-1:0] d, input logic ordy);
    int  n;
    bit  acc;
    bit  do_push;
    bit  do_pop;
    compareAll();
    enable    = en;
    id_clr    = clr;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    n       = q_data.size();
    acc     = (m_state == M_RUN) && (n < DEPTH);
    do_push = iv && acc;
    do_pop  = ordy && (n != 0);
    if (do_pop) begin
      last_data = q_data.pop_front();
      last_id   = q_id.pop_front();
    end
    if (do_push) begin
      q_data.push_back(int'(d));
      q_id.push_back(int'(m_id));
      m_id = (m_id + 1) % (1 << IW);
    end
    if (m_state == M_IDLE && clr) m_id = 0;
    case (m_state)
      M_IDLE:  if (en) m_state = M_RUN;
      M_RUN:   if (!en) m_state = (n != 0) ? M_DRAIN : M_IDLE;
      default: if (en) m_state = M_RUN; else if (n == 0) m_state = M_IDLE;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    modelReset();
    #12;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream
    applyStimulus(1, 0, 0, 8'h00, 1);
    applyStimulus(1, 0, 1, 8'h11, 1);
    applyStimulus(1, 0, 1, 8'h22, 1);
    applyStimulus(1, 0, 1, 8'h33, 1);
    repeat (3) applyStimulus(1, 0, 0, 8'h00, 1);

    // Backpressure until full, then release
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, DW'($urandom), 0);
    repeat (2) applyStimulus(1, 0, 1, DW'($urandom), 0);
    repeat (8) applyStimulus(1, 0, 0, 8'h00, 1);

    // Drain
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, DW'($urandom), 0);
    repeat (2) applyStimulus(0, 0, 1, DW'($urandom), 0);
    repeat (6) applyStimulus(0, 0, 1, DW'($urandom), 1);

    // id_clr honoured in IDLE, ignored in RUN
    applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, DW'($urandom), 1);
    applyStimulus(1, 1, 1, DW'($urandom), 1);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1, DW'($urandom), 1);
    repeat (3) applyStimulus(0, 0, 0, 8'h00, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) < 8, DW'($urandom), $urandom_range(0, 9) < 3);
    end

    // Asynchronous reset with three words queued
    applyStimulus(1, 0, 0, 8'h00, 1);
    repeat (4) applyStimulus(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, DW'($urandom), 0);
    checkOutput("pre_reset_level", level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_out_valid", out_valid, 0);
    checkOutput("areset_level",     level,     0);
    checkOutput("areset_in_ready",  in_ready,  0);
    checkOutput("areset_busy",      busy,      0);
    checkOutput("areset_out_id",    out_id,    0);
    checkOutput("areset_out_data",  out_data,  0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 1, 8'h5a, 0);
    applyStimulus(1, 0, 1, 8'ha5, 1);
    repeat (4) applyStimulus(1, 0, 0, 8'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tagged_data_tx.md
Name: tagged_data_tx

Overview:
Transmit-side producer for the tagged data interface: the {data, id} pair that the downstream consumer samples.
- Accepts raw words from a local source and stamps each one with a monotonically increasing ID.
- Buffers stamped words in a small FIFO.
- Presents them to the consumer over a valid/ready handshake.
- Sits between the local data source and any DATA_WIDTH/ID_WIDTH-parameterised consumer.

Parameters:
DATA_WIDTH, 8, payload width in bits
ID_WIDTH, 32, ID/tag width in bits; counter wraps modulo 2**ID_WIDTH
DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
clk  input  1  single clock; all logic rising-edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = accept new words; 0 = stop accepting and drain
id_clr  input  1  synchronous clear of the ID counter to 0; honoured only in IDLE
in_valid  input  1  source word valid
in_ready  output  1  block can accept a word
in_data  input  DATA_WIDTH  source payload
out_valid  output  1  {out_data, out_id} valid
out_ready  input  1  consumer accepts
out_data  output  DATA_WIDTH  payload to consumer
out_id  output  ID_WIDTH  tag to consumer
level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
busy  output  1  state != IDLE

Behaviour:
- Clock, reset and handshakes: reset is the only asynchronous path and is fixed as one clock, asynchronous active-low. Handshake on each side completes when valid && ready at a rising edge.
- Reset values: state=IDLE, ID counter=0, FIFO empty, level=0, in_ready=0, out_valid=0, out_data=0, out_id=0, busy=0.
- FSM states:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0 and level!=0.
  - RUN -> IDLE when enable=0 and level==0.
  - DRAIN -> IDLE when level==0 after the final pop.
  - DRAIN -> RUN when enable=1 again; no word is lost.
- in_ready = (state==RUN) && (level<DEPTH). Combinational from registered state and level only; no dependency on in_valid.
- Push: on in_valid && in_ready, write {in_data, id_cnt} and increment id_cnt. Wrap 2**ID_WIDTH-1 -> 0 with no flag.
- id_clr: in IDLE, id_cnt <= 0; ignored in other states.
- Output side:
  - out_valid = (level!=0); out_data/out_id are the FIFO head.
  - Values are held stable while out_valid && !out_ready. No change is allowed until accepted.
- Pop: on out_valid && out_ready. Push and pop may happen in the same cycle; level is then unchanged.
- Full: level==DEPTH forces in_ready=0. A simultaneous pop does not reopen in_ready in that same cycle. The first-word latency below is the minimum.
- Empty: out_valid=0; out_data/out_id hold their last value (0 after reset).
- Latency: a word pushed at edge N is visible at the output after edge N when the FIFO was empty. One cycle, no bypass.
- Ordering: strict FIFO. Every word's out_id equals the previous word's out_id + 1 (mod 2**ID_WIDTH) since the last id_clr or reset.
- Reset mid-operation: FIFO contents are discarded, the counter returns to 0 and the outputs return to their reset values immediately.
- level is registered and updated on push/pop at the same edge as the FIFO pointers.

Decomposition:
- Package tagged_data_pkg holds:
  - tx_state_t enum {IDLE, RUN, DRAIN};
  - a typedef for the packed {data, id} entry, parameterised through the module;
  - localparam helpers for the level width.
- One sub-module, tagged_data_fifo: synchronous DEPTH-entry FIFO with push/pop/level, registered head. The top holds the FSM and the ID counter.

Test Plan:
- Basic stream: reset, enable=1, push 0x11, 0x22, 0x33, out_ready=1 -> out gets (0x11,id0), (0x22,id1), (0x33,id2); first out_valid one cycle after the first push.
- Backpressure/full: DEPTH=4, out_ready=0, push 6 words -> in_ready drops after 4, level=4, the head holds (data0,id0) stable; release out_ready -> ids 0..3 in order, then the remaining words.
- Wrap: ID_WIDTH=4, push 18 words -> ids 0..15, 0, 1 with no stall.
- Drain: 3 words queued, enable->0 -> in_ready=0, state DRAIN, all 3 delivered, then IDLE and busy=0.
- id_clr: after 5 words, return to IDLE, pulse id_clr, re-enable, push -> out_id=0; id_clr pulsed during RUN -> ignored, ids continue.
- Async reset mid-stream: assert rst_n=0 with level=3 -> out_valid=0, level=0, in_ready=0 without waiting for a clock edge; after release the next word gets id 0.
